// File: rtl/isr_dispatch_if.sv
// Valid/ready request and response streams between a producer/consumer and the
// isr_dispatch sequencer.
interface isr_dispatch_if #(
    parameter int unsigned TAG_W = 4
);
    logic             in_valid;
    logic             in_ready;
    logic [63:0]      in_value;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [31:0]      out_result;
    logic [TAG_W-1:0] out_tag;
    logic             out_timeout;

    modport master (
        output in_valid, in_value, in_tag, out_ready,
        input  in_ready, out_valid, out_result, out_tag, out_timeout
    );

    modport slave (
        input  in_valid, in_value, in_tag, out_ready,
        output in_ready, out_valid, out_result, out_tag, out_timeout
    );
endinterface

// File: rtl/isr_dispatch.sv
// Buffers radicands, launches them one at a time into an external ISR core,
// and returns roots (or watchdog timeouts) on a buffered output stream.
module isr_dispatch #(
    parameter int unsigned IN_DEPTH  = 4,
    parameter int unsigned OUT_DEPTH = 4,
    parameter int unsigned TIMEOUT   = 1023,
    parameter int unsigned TAG_W     = 4
) (
    input  logic               clock,
    input  logic               reset,
    isr_dispatch_if.slave      bus,
    output logic               busy,
    output logic               core_reset,
    output logic [63:0]        core_value,
    input  logic [31:0]        core_result,
    input  logic               core_done
);
    localparam int unsigned IN_AW  = $clog2(IN_DEPTH);
    localparam int unsigned OUT_AW = $clog2(OUT_DEPTH);
    localparam int unsigned OUT_W  = TAG_W + 33;
    localparam logic [IN_AW:0]  InFull     = IN_DEPTH[IN_AW:0];
    localparam logic [OUT_AW:0] OutFull    = OUT_DEPTH[OUT_AW:0];
    localparam logic [11:0]     TimeoutVal = TIMEOUT[11:0];

    typedef enum logic [1:0] {StIdle, StLoad, StGuard, StRun} state_e;

    state_e state_q, state_d;

    // Input FIFO
    logic [TAG_W+63:0] in_mem [IN_DEPTH];
    logic [IN_AW-1:0]  in_wr_q, in_rd_q;
    logic [IN_AW:0]    in_cnt_q;
    logic              in_push, in_pop;

    // Output FIFO
    logic [OUT_W-1:0]  out_mem [OUT_DEPTH];
    logic [OUT_AW-1:0] out_wr_q, out_rd_q;
    logic [OUT_AW:0]   out_cnt_q;
    logic              out_push, out_pop;
    logic [OUT_W-1:0]  out_data, out_head;

    logic [TAG_W-1:0]  job_tag_q;
    logic [11:0]       timer_q;
    logic              launch_ok;
    logic              timed_out;

    assign bus.in_ready = !reset && (in_cnt_q != InFull);
    assign in_push      = bus.in_valid && bus.in_ready;

    always_ff @(posedge clock) begin
        if (reset) begin
            in_wr_q  <= '0;
            in_rd_q  <= '0;
            in_cnt_q <= '0;
        end else begin
            if (in_push) in_wr_q <= in_wr_q + 1'b1;
            if (in_pop)  in_rd_q <= in_rd_q + 1'b1;
            case ({in_push, in_pop})
                2'b10:   in_cnt_q <= in_cnt_q + 1'b1;
                2'b01:   in_cnt_q <= in_cnt_q - 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (in_push) in_mem[in_wr_q] <= {bus.in_tag, bus.in_value};
    end

    assign bus.out_valid = (out_cnt_q != '0);
    assign out_pop       = bus.out_valid && bus.out_ready;
    assign out_head      = out_mem[out_rd_q];

    // Head is masked while empty so the stream reads as all-zero after reset.
    assign bus.out_tag     = bus.out_valid ? out_head[OUT_W-1 -: TAG_W] : '0;
    assign bus.out_result  = bus.out_valid ? out_head[32:1] : '0;
    assign bus.out_timeout = bus.out_valid && out_head[0];

    always_ff @(posedge clock) begin
        if (reset) begin
            out_wr_q  <= '0;
            out_rd_q  <= '0;
            out_cnt_q <= '0;
        end else begin
            if (out_push) out_wr_q <= out_wr_q + 1'b1;
            if (out_pop)  out_rd_q <= out_rd_q + 1'b1;
            case ({out_push, out_pop})
                2'b10:   out_cnt_q <= out_cnt_q + 1'b1;
                2'b01:   out_cnt_q <= out_cnt_q - 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (out_push) out_mem[out_wr_q] <= out_data;
    end

    // Reserving an output slot at launch means a completion can never be dropped.
    assign launch_ok = (in_cnt_q != '0) && (out_cnt_q != OutFull);
    assign timed_out = (timer_q == TimeoutVal);

    always_ff @(posedge clock) begin
        if (reset) state_q <= StIdle;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (launch_ok) state_d = StLoad;
            StLoad:  state_d = StGuard;
            StGuard: state_d = StRun;
            StRun:   if (core_done || timed_out) state_d = StIdle;
        endcase
    end

    always_comb begin
        in_pop     = 1'b0;
        out_push   = 1'b0;
        out_data   = '0;
        core_reset = reset;
        busy       = (state_q != StIdle);
        unique case (state_q)
            StIdle:  in_pop = launch_ok;
            StLoad:  core_reset = 1'b1;
            StGuard: ;
            StRun: begin
                if (core_done) begin
                    out_push = 1'b1;
                    out_data = {job_tag_q, core_result, 1'b0};
                end else if (timed_out) begin
                    out_push = 1'b1;
                    out_data = {job_tag_q, 32'h0, 1'b1};
                end
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            core_value <= '0;
            job_tag_q  <= '0;
            timer_q    <= '0;
        end else begin
            if (in_pop) {job_tag_q, core_value} <= in_mem[in_rd_q];
            if (state_q == StGuard)    timer_q <= '0;
            else if (state_q == StRun) timer_q <= timer_q + 1'b1;
        end
    end
endmodule

// File: tb/tb_isr_dispatch.sv
// Directed bench for isr_dispatch with a behavioural ISR core that can also
// be forced to hold done low (hang) or high (garbage right after reset).
module tb_isr_dispatch;
    localparam int unsigned TAG_W   = 4;
    localparam int unsigned CORE_LAT = 3;

    typedef struct {
        logic [63:0]      value;
        logic [TAG_W-1:0] tag;
        logic [31:0]      exp_result;
        logic             exp_timeout;
    } vec_t;

    logic        clock = 1'b0;
    logic        reset;
    logic        busy, core_reset, core_done;
    logic [63:0] core_value;
    logic [31:0] core_result;

    isr_dispatch_if #(.TAG_W(TAG_W)) bus ();

    isr_dispatch #(
        .IN_DEPTH (4),
        .OUT_DEPTH(4),
        .TIMEOUT  (15),
        .TAG_W    (TAG_W)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .bus        (bus.slave),
        .busy       (busy),
        .core_reset (core_reset),
        .core_value (core_value),
        .core_result(core_result),
        .core_done  (core_done)
    );

    always #5 clock = ~clock;

    // Core model: 0 = normal, 1 = done stuck low, 2 = done stuck high
    int          mode = 0;
    int          core_cnt;
    logic [63:0] core_val_l;

    function automatic logic [31:0] isqrt(input logic [63:0] v);
        logic [63:0] op, res, one;
        op  = v;
        res = 64'd0;
        one = 64'd1 << 62;
        while (one > op) one = one >> 2;
        while (one != 64'd0) begin
            if (op >= res + one) begin
                op  = op - (res + one);
                res = (res >> 1) + one;
            end else begin
                res = res >> 1;
            end
            one = one >> 2;
        end
        return res[31:0];
    endfunction

    always @(posedge clock) begin
        if (core_reset) begin
            core_cnt   <= 0;
            core_val_l <= core_value;
        end else if (core_cnt < CORE_LAT) begin
            core_cnt <= core_cnt + 1;
        end
    end

    assign core_result = isqrt(core_val_l);
    assign core_done   = (mode == 2) ? 1'b1 : (mode == 1) ? 1'b0 : (core_cnt == CORE_LAT);

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // core_value stability and core_reset pulse-width monitors
    int          stab_err = 0;
    logic [63:0] held;
    bit          tracking = 0;
    int          pulse_run = 0, pulse_max = 0, pulses = 0;

    always @(negedge clock) begin
        if (!reset) begin
            if (core_reset) begin
                held     = core_value;
                tracking = 1;
            end else if (busy && tracking) begin
                if (core_value !== held) stab_err++;
            end else if (!busy) begin
                tracking = 0;
            end
            if (core_reset) begin
                if (pulse_run == 0) pulses++;
                pulse_run++;
            end else begin
                if (pulse_run > pulse_max) pulse_max = pulse_run;
                pulse_run = 0;
            end
        end else begin
            tracking  = 0;
            pulse_run = 0;
        end
    end

    task automatic send(input logic [63:0] v, input logic [TAG_W-1:0] t);
        int n = 0;
        bus.in_valid = 1'b1;
        bus.in_value = v;
        bus.in_tag   = t;
        while (!bus.in_ready && n < 500) begin
            @(negedge clock);
            n++;
        end
        if (!bus.in_ready) check("send_accept", 64'(bus.in_ready), 64'd1);
        @(negedge clock);
        bus.in_valid = 1'b0;
    endtask

    task automatic recv(input string name, input logic [31:0] r, input logic [TAG_W-1:0] t,
                        input logic to);
        int n = 0;
        bus.out_ready = 1'b1;
        while (!bus.out_valid && n < 500) begin
            @(negedge clock);
            n++;
        end
        check({name, "_valid"}, 64'(bus.out_valid), 64'd1);
        if (bus.out_valid) begin
            check({name, "_result"}, 64'(bus.out_result), 64'(r));
            check({name, "_tag"}, 64'(bus.out_tag), 64'(t));
            check({name, "_timeout"}, 64'(bus.out_timeout), 64'(to));
        end
        @(negedge clock);
    endtask

    task automatic wait_core_reset();
        int n = 0;
        while (!core_reset && n < 200) begin
            @(negedge clock);
            n++;
        end
        check("core_reset_seen", 64'(core_reset), 64'd1);
    endtask

    vec_t vecs[8];
    int   sent;
    int   lat;

    initial begin
        vecs[0] = '{64'd0, 4'd0, 32'd0, 1'b0};
        vecs[1] = '{64'd1, 4'd1, 32'd1, 1'b0};
        vecs[2] = '{64'hFFFF_FFFF_FFFF_FFFF, 4'd2, 32'hFFFF_FFFF, 1'b0};
        vecs[3] = '{64'd1000000000000, 4'd3, 32'd1000000, 1'b0};
        vecs[4] = '{64'd144, 4'd4, 32'd12, 1'b0};
        vecs[5] = '{64'd99, 4'd5, 32'd9, 1'b0};
        vecs[6] = '{64'd100, 4'd6, 32'd10, 1'b0};
        vecs[7] = '{64'h1_0000_0000, 4'd7, 32'd65536, 1'b0};

        reset         = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_value  = '0;
        bus.in_tag    = '0;
        bus.out_ready = 1'b0;
        repeat (3) @(negedge clock);
        check("rst_in_ready", 64'(bus.in_ready), 64'd0);
        check("rst_core_reset", 64'(core_reset), 64'd1);
        reset = 1'b0;
        @(negedge clock);
        check("post_in_ready", 64'(bus.in_ready), 64'd1);
        check("post_out_valid", 64'(bus.out_valid), 64'd0);
        check("post_out_result", 64'(bus.out_result), 64'd0);
        check("post_out_tag", 64'(bus.out_tag), 64'd0);
        check("post_out_timeout", 64'(bus.out_timeout), 64'd0);
        check("post_busy", 64'(busy), 64'd0);
        check("post_core_value", core_value, 64'd0);

        // Single request with launch-latency checks
        bus.out_ready = 1'b1;
        send(64'd144, 4'd3);
        check("lat_t1_busy", 64'(busy), 64'd0);
        @(negedge clock);
        check("lat_load_core_reset", 64'(core_reset), 64'd1);
        check("lat_load_core_value", core_value, 64'd144);
        @(negedge clock);
        check("lat_guard_core_reset", 64'(core_reset), 64'd0);
        check("lat_guard_busy", 64'(busy), 64'd1);
        lat = 0;
        while (!bus.out_valid && lat < 100) begin
            @(negedge clock);
            lat++;
        end
        check("single_busy_drop", 64'(busy), 64'd0);
        recv("single", 32'd12, 4'd3, 1'b0);

        // Table: stream all vectors back to back with a concurrent collector
        fork
            for (int i = 0; i < 8; i++) send(vecs[i].value, vecs[i].tag);
            for (int j = 0; j < 8; j++)
                recv($sformatf("vec%0d", j), vecs[j].exp_result, vecs[j].tag,
                     vecs[j].exp_timeout);
        join

        // Backpressure: 4 results park in the output FIFO, 4 requests in the input FIFO
        bus.out_ready = 1'b0;
        sent = 0;
        fork
            for (int i = 0; i < 8; i++) begin
                send(vecs[i].value, vecs[i].tag);
                sent++;
            end
        join_none
        repeat (80) @(negedge clock);
        check("bp_all_accepted", 64'(sent), 64'd8);
        check("bp_out_valid", 64'(bus.out_valid), 64'd1);
        check("bp_no_launch", 64'(busy), 64'd0);
        check("bp_in_ready", 64'(bus.in_ready), 64'd0);
        check("bp_head_tag", 64'(bus.out_tag), 64'd0);
        for (int j = 0; j < 8; j++)
            recv($sformatf("bp%0d", j), vecs[j].exp_result, vecs[j].tag, vecs[j].exp_timeout);

        // Hung core: LOAD + GUARD + 16 RUN cycles, then the queued job runs normally
        mode = 1;
        fork
            begin
                send(64'd50, 4'd7);
                send(64'd49, 4'd8);
            end
        join_none
        wait_core_reset();
        lat = 0;
        while (!bus.out_valid && lat < 60) begin
            @(negedge clock);
            lat++;
        end
        check("to_latency", 64'(lat), 64'd18);
        mode = 0;
        recv("to_first", 32'd0, 4'd7, 1'b1);
        recv("to_next", 32'd7, 4'd8, 1'b0);

        // Done stuck high: ignored in GUARD, completes on first RUN cycle
        mode = 2;
        fork
            send(64'd200, 4'd9);
        join_none
        wait_core_reset();
        lat = 0;
        while (!bus.out_valid && lat < 60) begin
            @(negedge clock);
            lat++;
        end
        check("stuck1_latency", 64'(lat), 64'd3);
        recv("stuck1", 32'd14, 4'd9, 1'b0);
        mode = 0;

        // Reset mid-RUN with two queued requests
        mode = 1;
        fork
            begin
                send(64'd10, 4'd1);
                send(64'd20, 4'd2);
                send(64'd30, 4'd3);
            end
        join_none
        wait_core_reset();
        repeat (6) @(negedge clock);
        check("mr_pre_busy", 64'(busy), 64'd1);
        reset = 1'b1;
        @(negedge clock);
        check("mr_core_reset", 64'(core_reset), 64'd1);
        check("mr_busy", 64'(busy), 64'd0);
        check("mr_out_valid", 64'(bus.out_valid), 64'd0);
        reset = 1'b0;
        mode  = 0;
        @(negedge clock);
        check("mr_post_in_ready", 64'(bus.in_ready), 64'd1);
        check("mr_post_core_value", core_value, 64'd0);
        repeat (20) @(negedge clock);
        check("mr_queue_flushed", 64'(busy), 64'd0);
        check("mr_no_output", 64'(bus.out_valid), 64'd0);
        send(64'd81, 4'd1);
        recv("mr_81", 32'd9, 4'd1, 1'b0);

        repeat (3) @(negedge clock);
        check("core_value_stable", 64'(stab_err), 64'd0);
        check("core_reset_width", 64'(pulse_max), 64'd1);
        check("core_reset_pulses", 64'(pulses), 64'd22);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end
endmodule

// File: doc/isr_dispatch.md
# isr_dispatch

Front-end sequencer for the integer square-root core. Accepts 64-bit radicands over a valid/ready input stream, buffers them, and launches them one at a time into an external `ISR` instance. It launches each job by driving `core_value` and pulsing `core_reset`. It collects each 32-bit root when `core_done` rises and returns it on a valid/ready output stream, so the core can sit in a streaming datapath with backpressure and a hang watchdog.

## Interface
- `IN_DEPTH`, 4: input FIFO entries (power of two, ≥2)
- `OUT_DEPTH`, 4: output FIFO entries (power of two, ≥2)
- `TIMEOUT`, 1023: max RUN cycles before a job is abandoned (≥1, fits in 12 bits)
- `TAG_W`, 4: width of the pass-through request tag
- `clock`  in  1  single clock, all state on posedge
- `reset`  in  1  synchronous, active-high
- `in_valid`  in  1  request present
- `in_ready`  out  1  input FIFO not full (registered)
- `in_value`  in  64  radicand
- `in_tag`  in  TAG_W  request tag
- `out_valid`  out  1  output FIFO not empty
- `out_ready`  in  1  consumer accepts
- `out_result`  out  32  floor(sqrt(value)); 0 on timeout
- `out_tag`  out  TAG_W  tag of the completed request
- `out_timeout`  out  1  job abandoned by watchdog
- `busy`  out  1  FSM not in IDLE
- `core_reset`  out  1  to ISR `reset`; loads `core_value` into core
- `core_value`  out  64  to ISR `value`; registered, held for whole job
- `core_result`  in  32  from ISR `result`
- `core_done`  in  1  from ISR `done`

## Operation
- Input FIFO: push on `in_valid & in_ready`. `in_ready` = !full, from registered count, so there is no same-cycle full bypass. A push to a full FIFO cannot occur.
- Output FIFO: pop on `out_valid & out_ready`. Head drives `out_result/out_tag/out_timeout`. A push into an empty FIFO makes `out_valid` visible the next cycle (no bypass). Simultaneous push/pop at any occupancy keeps count unchanged.
- One job in flight max. FSM states:
  - IDLE: if input FIFO non-empty and output FIFO not full, pop head into `core_value`/job tag → LOAD. Otherwise stay.
  - LOAD: `core_reset`=1 for exactly this cycle → GUARD.
  - GUARD: `core_done` ignored (core output invalid right after reset), timer cleared → RUN.
  - RUN: if `core_done`, push {tag, `core_result`, 0} → IDLE. Else if timer == TIMEOUT, push {tag, 32'h0, 1} → IDLE. Else timer+1. `core_done` takes priority over timeout in the same cycle.
- The output FIFO not-full check at launch guarantees space at completion, because the dispatcher is the only pusher. No completion is ever dropped.
- `core_value` changes only on a pop in IDLE. It is stable from LOAD through the end of RUN.
- `busy` = (state != IDLE).
- Reset (including mid-job): both FIFOs emptied, state IDLE, timer 0, `core_value` 0. The in-flight job is discarded with no output.

## Timing
- Reset values: `in_ready`=0 during reset, 1 the first cycle after. `out_valid`=0, `out_result`=0, `out_tag`=0, `out_timeout`=0, `busy`=0, `core_value`=0.
- `core_reset` = `reset` | (state==LOAD). The core is held in reset whenever the dispatcher is.
- Launch latency: request accepted at edge T, in FIFO at T+1, popped at edge T+1 (IDLE), LOAD during cycle T+1..T+2, GUARD next, RUN from T+3.
- Completion: `core_done` sampled high at edge E in RUN gives `out_valid` high after E (when the FIFO was empty). The next launch can pop at E+1.
- Per-job overhead outside the core: 3 cycles (IDLE, LOAD, GUARD) plus 1 cycle output FIFO latency.
- Timeout: RUN lasts at most TIMEOUT+1 cycles.

## Test plan
- Single request 144, tag 3, `out_ready`=1 → one output: result 12, tag 3, timeout 0. `core_reset` high exactly one cycle. `busy` drops after completion.
- Back-to-back 0, 1, 2^64-1, 10^12, tags 0..3 → results 0, 1, 32'hFFFFFFFF, 1000000 in order with matching tags. Each job's `core_value` held stable through RUN.
- `out_ready`=0, push 8 requests (depths 4) → 4 results queue, no 5th launch, `in_ready` falls once the input FIFO fills. Release `out_ready` → all 8 results delivered in order, none lost.
- Stub core with `core_done` stuck 0, TIMEOUT=15 → output result 0, timeout 1 exactly 16 RUN cycles after GUARD. The next queued job launches normally.
- Stub core with `core_done` stuck 1 → done ignored in GUARD, first RUN cycle completes the job. Confirms no completion during LOAD/GUARD.
- Assert `reset` mid-RUN with 2 queued requests → next cycle `busy`=0, `out_valid`=0, FIFOs empty, `core_reset` high during reset. Post-reset request 81 → result 9.
